// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared state encoding, ASCII constants and operator codes for
//               the UART calculator sequencer. Optional macro: CALC_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam logic [8:0] ST_GET_A  = 9'b0_0000_0001;
    localparam logic [8:0] ST_FIN_A  = 9'b0_0000_0010;
    localparam logic [8:0] ST_WAIT_A = 9'b0_0000_0100;
    localparam logic [8:0] ST_GET_B  = 9'b0_0000_1000;
    localparam logic [8:0] ST_FIN_B  = 9'b0_0001_0000;
    localparam logic [8:0] ST_WAIT_B = 9'b0_0010_0000;
    localparam logic [8:0] ST_EXEC   = 9'b0_0100_0000;
    localparam logic [8:0] ST_OUT    = 9'b0_1000_0000;
    localparam logic [8:0] ST_ERR    = 9'b1_0000_0000;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_AND   = 8'h26;
    localparam logic [7:0] ASCII_MUL   = 8'h2A;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SP    = 8'h20;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    // Single-cycle operators; the product comes from a separate register stage.
    function automatic logic [31:0] calc_alu(input logic [1:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            OP_ADD:  calc_alu = a + b;
            OP_SUB:  calc_alu = a - b;
            default: calc_alu = a & b;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_char_class.sv
// ============================================================================
// Module      : calc_char_class
// Description : Combinational byte classifier (digit/op/term/space/invalid),
//               digit value and operator code. Honours macro CALC_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_char_class
    import calc_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_digit,
    output logic       o_is_op,
    output logic       o_is_term,
    output logic       o_is_space,
    output logic       o_is_invalid,
    output logic [7:0] o_digit,
    output logic [1:0] o_op
);

    always_comb begin
        o_is_digit   = 1'b0;
        o_is_op      = 1'b0;
        o_is_term    = 1'b0;
        o_is_space   = 1'b0;
        o_is_invalid = 1'b0;
        o_op         = OP_ADD;
        o_digit      = i_byte - ASCII_0;
        if (i_byte >= ASCII_0 && i_byte <= ASCII_9) begin
            o_is_digit = 1'b1;
        end else if (i_byte == ASCII_SP) begin
            o_is_space = 1'b1;
        end else if (i_byte == ASCII_EQ || i_byte == ASCII_CR) begin
            o_is_term = 1'b1;
        end else if (i_byte == ASCII_PLUS) begin
            o_is_op = 1'b1;
            o_op    = OP_ADD;
        end else if (i_byte == ASCII_MINUS) begin
            o_is_op = 1'b1;
            o_op    = OP_SUB;
        end else if (i_byte == ASCII_AND) begin
            o_is_op = 1'b1;
            o_op    = OP_AND;
`ifdef CALC_MUL_EN
        end else if (i_byte == ASCII_MUL) begin
            o_is_op = 1'b1;
            o_op    = OP_MUL;
`endif
        end else begin
            o_is_invalid = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module      : calc_sequencer
// Description : Parses "<digits> <op> <digits> <term>", drives the digit
//               converter and evaluates the result. Optional macro: CALC_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 9,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_conv_dato,
    output logic        o_conv_num_ready,
    output logic        o_conv_fin,
    output logic        o_conv_clear,
    input  logic [31:0] i_conv_result,
    input  logic        i_conv_done,
    output logic [31:0] o_result,
    output logic        o_result_valid,
    output logic [1:0]  o_op_code,
    output logic        o_err
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] c_max_digits = DW'(MAX_DIGITS);
    localparam logic [TW-1:0] c_timer_last = TW'(TIMEOUT - 1);

    logic [8:0]    r_state, w_next;
    logic [DW-1:0] r_dcnt;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_opa, r_opb, r_result;
    logic [7:0]    r_dato;
    logic [1:0]    r_op_code;
    logic          r_num_ready, r_fin, r_clear, r_err, r_result_valid;
`ifdef CALC_MUL_EN
    logic [31:0]   r_prod;
    logic          r_mul_phase;
`endif

    logic       w_is_digit, w_is_op, w_is_term, w_is_space, w_is_invalid;
    logic [7:0] w_digit;
    logic [1:0] w_op;
    logic       w_in_get, w_accept;

    calc_char_class u_class (
        .i_byte       (i_rx_data),
        .o_is_digit   (w_is_digit),
        .o_is_op      (w_is_op),
        .o_is_term    (w_is_term),
        .o_is_space   (w_is_space),
        .o_is_invalid (w_is_invalid),
        .o_digit      (w_digit),
        .o_op         (w_op)
    );

    assign w_in_get = (r_state == ST_GET_A) || (r_state == ST_GET_B);
    assign w_accept = w_in_get && i_rx_valid && w_is_digit && (r_dcnt != c_max_digits);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_GET_A, ST_GET_B: begin
                if (i_rx_valid) begin
                    if (w_is_invalid) begin
                        w_next = ST_ERR;
                    end else if (w_is_digit) begin
                        if (r_dcnt == c_max_digits) w_next = ST_ERR;
                    end else if (w_is_space) begin
                        w_next = r_state;
                    end else if (r_state == ST_GET_A && w_is_op) begin
                        w_next = (r_dcnt == '0) ? ST_ERR : ST_FIN_A;
                    end else if (r_state == ST_GET_B && w_is_term) begin
                        w_next = (r_dcnt == '0) ? ST_ERR : ST_FIN_B;
                    end else begin
                        w_next = ST_ERR;
                    end
                end
            end
            ST_FIN_A: w_next = ST_WAIT_A;
            ST_FIN_B: w_next = ST_WAIT_B;
            // A byte arriving while the converter is busy is an overrun.
            ST_WAIT_A, ST_WAIT_B: begin
                if (i_rx_valid)                  w_next = ST_ERR;
                else if (i_conv_done)            w_next = (r_state == ST_WAIT_A) ? ST_GET_B : ST_EXEC;
                else if (r_timer == c_timer_last) w_next = ST_ERR;
            end
`ifdef CALC_MUL_EN
            ST_EXEC: w_next = r_mul_phase ? ST_OUT : ST_EXEC;
`else
            ST_EXEC: w_next = ST_OUT;
`endif
            default: w_next = ST_GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_GET_A;
            r_dcnt         <= '0;
            r_timer        <= '0;
            r_opa          <= '0;
            r_opb          <= '0;
            r_result       <= '0;
            r_dato         <= '0;
            r_op_code      <= OP_ADD;
            r_num_ready    <= 1'b0;
            r_fin          <= 1'b0;
            r_clear        <= 1'b0;
            r_err          <= 1'b0;
            r_result_valid <= 1'b0;
`ifdef CALC_MUL_EN
            r_prod         <= '0;
            r_mul_phase    <= 1'b0;
`endif
        end else begin
            r_state        <= w_next;
            r_num_ready    <= w_accept;
            r_fin          <= (r_state == ST_FIN_A) || (r_state == ST_FIN_B);
            r_err          <= (w_next == ST_ERR);
            r_clear        <= (w_next == ST_ERR);
            r_result_valid <= (r_state == ST_EXEC) && (w_next == ST_OUT);
            if (w_accept) begin
                r_dato <= w_digit;
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (r_state == ST_GET_A && w_next == ST_FIN_A) r_op_code <= w_op;
            case (r_state)
                ST_FIN_A, ST_FIN_B: begin
                    r_dcnt  <= '0;
                    r_timer <= '0;
                end
                ST_WAIT_A, ST_WAIT_B: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_next == ST_GET_B) r_opa <= i_conv_result;
                    if (w_next == ST_EXEC)  r_opb <= i_conv_result;
                end
                ST_EXEC: begin
`ifdef CALC_MUL_EN
                    if (!r_mul_phase) begin
                        r_prod      <= r_opa * r_opb;
                        r_mul_phase <= 1'b1;
                    end else begin
                        r_mul_phase <= 1'b0;
                        r_result    <= (r_op_code == OP_MUL) ? r_prod
                                                             : calc_alu(r_op_code, r_opa, r_opb);
                    end
`else
                    r_result <= calc_alu(r_op_code, r_opa, r_opb);
`endif
                end
                ST_ERR: begin
                    r_dcnt <= '0;
                    r_opa  <= '0;
                    r_opb  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_conv_dato      = r_dato;
    assign o_conv_num_ready = r_num_ready;
    assign o_conv_fin       = r_fin;
    assign o_conv_clear     = r_clear;
    assign o_result         = r_result;
    assign o_result_valid   = r_result_valid;
    assign o_op_code        = r_op_code;
    assign o_err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Self-checking bench for calc_sequencer with an expression-level
//               reference model and a converter model. Honours CALC_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

    localparam int MAXD = 9;
    localparam int TMO  = 64;
`ifdef CALC_MUL_EN
    localparam bit MUL_EN   = 1'b1;
    localparam int EXEC_LAT = 3;
`else
    localparam bit MUL_EN   = 1'b0;
    localparam int EXEC_LAT = 2;
`endif

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] conv_result = '0;
    logic        conv_done = 1'b0;
    logic [7:0]  conv_dato;
    logic        conv_num_ready, conv_fin, conv_clear, result_valid, err;
    logic [31:0] result;
    logic [1:0]  op_code;

    always #5 clk = ~clk;

    calc_sequencer #(.MAX_DIGITS(MAXD), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_rx_data        (rx_data),
        .i_rx_valid       (rx_valid),
        .o_conv_dato      (conv_dato),
        .o_conv_num_ready (conv_num_ready),
        .o_conv_fin       (conv_fin),
        .o_conv_clear     (conv_clear),
        .i_conv_result    (conv_result),
        .i_conv_done      (conv_done),
        .o_result         (result),
        .o_result_valid   (result_valid),
        .o_op_code        (op_code),
        .o_err            (err)
    );

    int n_checks = 0, n_errors = 0, cyc = 0;
    int cnt_nr = 0, cnt_fin = 0, cnt_err = 0, cnt_clr = 0, cnt_res = 0, cnt_done = 0;
    int last_nr_cyc, last_fin_cyc, last_err_cyc, last_res_cyc, last_done_cyc, last_rx_cyc;
    logic [31:0] last_result = '0;
    logic [1:0]  last_op = '0;
    byte unsigned exp_dig[$];
    logic [31:0]  exp_res[$];
    logic [1:0]   exp_op[$];
    int exp_fin = 0, exp_err = 0;
    logic [31:0] conv_acc = '0;
    bit conv_pend = 0, conv_mute = 0;
    int conv_cnt = 0, conv_delay = 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Output monitor, event checker and converter model.
    initial forever begin
        @(negedge clk);
        conv_done = 1'b0;
        if (conv_num_ready) begin
            cnt_nr++; last_nr_cyc = cyc;
            if (exp_dig.size() == 0) chk("num_ready_unexpected", 1, 0);
            else chk("conv_dato", {24'h0, conv_dato}, {24'h0, exp_dig.pop_front()});
            conv_acc = conv_acc * 10 + {24'h0, conv_dato};
        end
        if (conv_fin) begin
            cnt_fin++; last_fin_cyc = cyc;
            if (exp_fin == 0) chk("fin_unexpected", 1, 0); else exp_fin--;
            if (!conv_mute) begin conv_pend = 1; conv_cnt = conv_delay; end
        end
        if (err || conv_clear) chk("clear_with_err", {31'h0, conv_clear}, {31'h0, err});
        if (err) begin
            cnt_err++; last_err_cyc = cyc;
            if (exp_err == 0) chk("err_unexpected", 1, 0); else exp_err--;
        end
        if (conv_clear) begin cnt_clr++; conv_acc = '0; conv_pend = 0; end
        if (result_valid) begin
            cnt_res++; last_res_cyc = cyc; last_result = result; last_op = op_code;
            if (exp_res.size() == 0) chk("result_valid_unexpected", 1, 0);
            else begin
                chk("result", result, exp_res.pop_front());
                chk("op_code", {30'h0, op_code}, {30'h0, exp_op.pop_front()});
            end
        end
        if (conv_pend) begin
            if (conv_cnt == 0) begin
                conv_done = 1'b1; conv_result = conv_acc; conv_acc = '0; conv_pend = 0;
                cnt_done++; last_done_cyc = cyc;
            end else conv_cnt--;
        end
    end

    // Expression-level reference: pushes the expected events for s.
    task automatic model(input bq_t s, output int err_idx, output int op_idx);
        logic [31:0] va = 0, vb = 0, r;
        int phase = 0, cnt = 0;
        logic [1:0] op = 0;
        byte unsigned c;
        err_idx = -1; op_idx = -1;
        for (int i = 0; i < s.size(); i++) begin
            c = s[i];
            if (c >= 8'h30 && c <= 8'h39) begin
                if (cnt == MAXD) begin err_idx = i; break; end
                exp_dig.push_back(c - 8'h30); cnt++;
                if (phase == 0) va = va * 10 + 32'(c - 8'h30);
                else            vb = vb * 10 + 32'(c - 8'h30);
            end else if (c == 8'h20) begin
                continue;
            end else if (phase == 0 && (c == 8'h2B || c == 8'h2D || c == 8'h26 || (MUL_EN && c == 8'h2A))) begin
                if (cnt == 0) begin err_idx = i; break; end
                op = (c == 8'h2B) ? 2'd0 : (c == 8'h2D) ? 2'd1 : (c == 8'h26) ? 2'd2 : 2'd3;
                exp_fin++; phase = 1; cnt = 0; op_idx = i;
            end else if (phase == 1 && (c == 8'h3D || c == 8'h0D)) begin
                if (cnt == 0) begin err_idx = i; break; end
                exp_fin++;
                case (op)
                    2'd0: r = va + vb;
                    2'd1: r = va - vb;
                    2'd2: r = va & vb;
                    default: r = va * vb;
                endcase
                exp_res.push_back(r); exp_op.push_back(op);
                return;
            end else begin
                err_idx = i; break;
            end
        end
        if (err_idx >= 0) exp_err++;
    endtask

    task automatic put(input byte unsigned b);
        @(negedge clk); rx_data = b; rx_valid = 1'b1; last_rx_cyc = cyc;
    endtask

    task automatic idle();
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < TMO + 200 && cnt_done == d0; k++) @(posedge clk);
        if (cnt_done == d0) chk("wait_conv_done", 0, 1);
    endtask

    task automatic send_expr(input bq_t s);
        int e, o, n, r0, e0, d0;
        r0 = cnt_res; e0 = cnt_err;
        model(s, e, o);
        n = (e >= 0) ? e + 1 : s.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            d0 = cnt_done;
            put(s[i]);
            if (i == o) begin idle(); wait_done(d0); end
        end
        idle();
        for (int k = 0; k < 2000 && cnt_res == r0 && cnt_err == e0; k++) @(posedge clk);
        if (cnt_res == r0 && cnt_err == e0) chk("wait_expr_end", 0, 1);
    endtask

    function automatic bq_t to_bq(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t gen();
        bq_t q;
        byte unsigned ops[4] = '{8'h2B, 8'h2D, 8'h26, 8'h2A};
        int r, nd;
        for (int k = 0; k < 2; k++) begin
            r  = $urandom_range(0, 19);
            nd = (r == 0) ? 0 : (r == 1) ? 10 : $urandom_range(1, 9);
            for (int j = 0; j < nd; j++) begin
                if ($urandom_range(0, 7) == 0) q.push_back(8'h20);
                q.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
            r = $urandom_range(0, 15);
            if (k == 0) q.push_back(r == 0 ? 8'h78 : r == 1 ? 8'h3D : ops[r % 4]);
            else        q.push_back(r == 0 ? 8'h2B : r[0] ? 8'h3D : 8'h0D);
        end
        return q;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, e0, c0, n0, r0, c3, d0;
        bq_t q;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_result_valid", {31'h0, result_valid}, 0);
        chk("rst_err", {31'h0, err}, 0);
        chk("rst_clear", {31'h0, conv_clear}, 0);
        chk("rst_fin", {31'h0, conv_fin}, 0);
        chk("rst_num_ready", {31'h0, conv_num_ready}, 0);
        chk("rst_dato", {24'h0, conv_dato}, 0);
        chk("rst_op_code", {30'h0, op_code}, 0);
        reset = 1'b1;

        n0 = cnt_nr; f0 = cnt_fin; r0 = cnt_res;
        send_expr(to_bq("12+34="));
        chk("t1_num_ready_count", cnt_nr - n0, 4);
        chk("t1_fin_count", cnt_fin - f0, 2);
        chk("t1_valid_count", cnt_res - r0, 1);
        chk("t1_result", last_result, 46);
        chk("t1_fin_latency", last_fin_cyc - last_rx_cyc, 2);
        chk("t1_exec_latency", last_res_cyc - last_done_cyc, EXEC_LAT);

        q = to_bq("5-9"); q.push_back(8'h0D);
        send_expr(q);
        chk("t2_result", last_result, 32'hFFFF_FFFC);
        chk("t2_op_code", {30'h0, last_op}, 1);

        f0 = cnt_fin; e0 = cnt_err; c0 = cnt_clr;
        send_expr(to_bq("+3="));
        chk("t3_err_count", cnt_err - e0, 1);
        chk("t3_clear_count", cnt_clr - c0, 1);
        chk("t3_fin_count", cnt_fin - f0, 0);
        send_expr(to_bq("7&3="));
        chk("t3_and_result", last_result, 3);

        n0 = cnt_nr; e0 = cnt_err;
        send_expr(to_bq("1234567890"));
        chk("t4_num_ready_count", cnt_nr - n0, 9);
        chk("t4_err_count", cnt_err - e0, 1);

        // Converter never answers: timeout.
        conv_mute = 1; e0 = cnt_err;
        begin int e, o; model(to_bq("5+"), e, o); end
        exp_err++;
        put(8'h35); put(8'h2B); idle();
        for (int k = 0; k < TMO + 100 && cnt_err == e0; k++) @(posedge clk);
        chk("t5_timeout_err", cnt_err - e0, 1);
        chk("t5_timeout_latency", last_err_cyc - last_fin_cyc, TMO);
        conv_mute = 0;

        // Byte arriving while waiting for the converter.
        conv_delay = 10; e0 = cnt_err;
        begin int e, o; model(to_bq("8+"), e, o); end
        exp_err++;
        put(8'h38); put(8'h2B); idle(); idle(); put(8'h39); idle();
        for (int k = 0; k < 50 && cnt_err == e0; k++) @(posedge clk);
        chk("t6_overrun_err", cnt_err - e0, 1);

        // Reset while waiting for operand B.
        conv_delay = 20;
        exp_dig.push_back(3); exp_dig.push_back(4); exp_fin += 2;
        put(8'h33); c3 = last_rx_cyc; idle(); idle();
        chk("t7_digit_latency", last_nr_cyc - c3, 1);
        d0 = cnt_done;
        put(8'h2D); idle(); wait_done(d0);
        put(8'h34); put(8'h3D); idle();
        repeat (5) idle();
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2;
        chk("t7_rst_result", result, 0);
        chk("t7_rst_valid", {31'h0, result_valid}, 0);
        chk("t7_rst_err", {31'h0, err}, 0);
        chk("t7_rst_clear", {31'h0, conv_clear}, 0);
        chk("t7_rst_fin", {31'h0, conv_fin}, 0);
        chk("t7_rst_op_code", {30'h0, op_code}, 0);
        conv_pend = 0; conv_acc = '0; reset = 1'b1;
        conv_delay = 2;
        send_expr(to_bq("1+1="));
        chk("t7_after_reset_result", last_result, 2);

        e0 = cnt_err;
        send_expr(to_bq("6*7="));
        if (MUL_EN) begin
            chk("t8_mul_result", last_result, 42);
            chk("t8_mul_latency", last_res_cyc - last_done_cyc, 3);
        end else begin
            chk("t8_mul_rejected", cnt_err - e0, 1);
        end

        for (int t = 0; t < 40; t++) begin
            conv_delay = $urandom_range(0, 6);
            send_expr(gen());
        end

        repeat (5) idle();
        chk("left_digits", exp_dig.size(), 0);
        chk("left_results", exp_res.size(), 0);
        chk("left_fins", exp_fin, 0);
        chk("left_errs", exp_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Controller that sits between the UART receiver and the digit-to-integer converter in the UART calculator. It parses the incoming ASCII stream `<digits> <op> <digits> <term>` and feeds each operand's digits to the converter one at a time. It pulses `fin` at the end of each operand, captures each converted value on `done`, evaluates the operation and presents a 32-bit result with a one-cycle valid strobe.

## Interface
- `MAX_DIGITS`, default 9: maximum digits per operand. A longer operand is an error.
- `TIMEOUT`, default 1024: clock cycles allowed between `conv_fin` and `conv_done`.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-low.
- `rx_data`, in, 8: received ASCII byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `conv_dato`, out, 8: digit value 0–9 (ASCII minus 0x30) sent to the converter.
- `conv_num_ready`, out, 1: one-cycle strobe; `conv_dato` is valid in the same cycle.
- `conv_fin`, out, 1: one-cycle end-of-operand strobe.
- `conv_clear`, out, 1: one-cycle converter flush, issued on error.
- `conv_result`, in, 32: converted operand value.
- `conv_done`, in, 1: one-cycle strobe; `conv_result` is valid in the same cycle.
- `result`, out, 32: operation result, two's complement.
- `result_valid`, out, 1: one-cycle strobe.
- `op_code`, out, 2: latched operator. 0 = `+`, 1 = `-`, 2 = `&`, 3 = `*`.
- `err`, out, 1: one-cycle error strobe.

## Operation
- States: `GET_A`, `FIN_A`, `WAIT_A`, `GET_B`, `FIN_B`, `WAIT_B`, `EXEC`, `OUT`, `ERR`.
- **GET_A**
  - Digit 0x30–0x39: forward it to the converter and increment `dcnt`.
  - Space (0x20): ignored.
  - Operator `+` (0x2B), `-` (0x2D) or `&` (0x26):
    - `dcnt == 0`: go to `ERR`.
    - Otherwise: latch `op_code` and go to `FIN_A`.
  - Any other byte: go to `ERR`.
- **FIN_A**: pulse `conv_fin`, clear `dcnt` and the timer, go to `WAIT_A`.
- **WAIT_A**
  - On `conv_done`: latch `opA <= conv_result`, go to `GET_B`.
  - Timer reaches `TIMEOUT`: go to `ERR`.
  - Any `rx_valid` in this state: go to `ERR` (overrun).
- **GET_B**
  - Digits and spaces are handled as in `GET_A`.
  - Terminator `=` (0x3D) or CR (0x0D):
    - `dcnt == 0`: go to `ERR`.
    - Otherwise: go to `FIN_B`.
  - Operator or any other byte: go to `ERR`.
- **FIN_B / WAIT_B**: same as `FIN_A / WAIT_A`; `conv_done` latches `opB` and goes to `EXEC`.
- **EXEC**: `res <= f(opA, opB)`.
  - Addition and subtraction are modulo 2^32; overflow is not flagged.
  - `&` is bitwise AND.
- **OUT**: `result <= res`, `result_valid = 1`, then go to `GET_A`.
- **ERR**: `err = 1` and `conv_clear = 1` for one cycle. Clear `dcnt`, `opA` and `opB`, then go to `GET_A`.
- A digit when `dcnt == MAX_DIGITS` goes to `ERR`. The digit is not forwarded.
- `rx_valid` is ignored in `FIN_x`, `EXEC`, `OUT` and `ERR`.
- Reset (sampled on `clk`, also mid-transaction):
  - State returns to `GET_A`.
  - `dcnt`, timer, `opA`, `opB` and `result` are cleared to 0; `op_code` is cleared to 0.
  - All strobes go low.
  - `conv_clear` is not issued; the converter shares the same reset.

## Timing
- Every output is a register. All outputs reset to 0.
- Accepted digit on `rx_valid` at cycle n: `conv_num_ready` and `conv_dato` appear at cycle n+1.
- Operator or terminator at cycle n: `FIN_x` at n+1, `conv_fin` asserted at cycle n+2.
- `conv_done` for B at cycle m: `EXEC` at m+1, `result_valid` at m+2.
- `err` asserts one cycle after the offending event.
- Back-to-back `rx_valid` on consecutive cycles is supported in `GET_x`.
- `conv_done` outside `WAIT_x` is ignored.

## Configuration
- Macro `CALC_MUL_EN`.
- **Defined**:
  - `*` (0x2A) is accepted as an operator, with `op_code = 3`.
  - `EXEC` computes the low 32 bits of `opA * opB`, using a registered multiplier.
  - `EXEC` then takes 2 cycles for all operators, so `result_valid` appears at m+3.
- **Undefined**:
  - `*` is an invalid byte and goes to `ERR`.
  - `op_code = 3` is never produced.
  - `EXEC` takes 1 cycle.

## Structure
- Shared package `calc_pkg`:
  - State encoding as one-hot localparams.
  - ASCII constants: `ASCII_0`, `ASCII_9`, `ASCII_PLUS`, `ASCII_MINUS`, `ASCII_AND`, `ASCII_MUL`, `ASCII_EQ`, `ASCII_CR`, `ASCII_SP`.
  - `op_code` values.
- One sub-module: `calc_char_class`. Combinational classifier from byte to {digit, op, term, space, invalid} plus digit value and `op_code`. It honours `CALC_MUL_EN`.

## Test plan
- Bytes "12+34=" with a model converter returning 12, then 34 → `conv_num_ready` pulses ×2 per operand, `conv_fin` ×2, `result = 46`, `result_valid` for exactly one cycle.
- "5-9\r" → `result = 0xFFFFFFFC`, `op_code = 1`.
- "+3=" (empty operand A) → `err` pulse and `conv_clear` pulse, no `conv_fin`; a following "7&3=" gives `result = 3`.
- Ten digits with `MAX_DIGITS = 9` → `err` on the 10th digit, only 9 `conv_num_ready` pulses; converter never answers `done` → `err` exactly `TIMEOUT` cycles after `conv_fin`.
- `reset` low during `WAIT_B` → all outputs 0 next cycle, state `GET_A`; "1+1=" then yields `result = 2`.
- With `CALC_MUL_EN`: "6*7=" → `result = 42` at m+3. Without it: "6*7=" → `err` on `*`.
